// File: rtl/pll_reset_sequencer_if.sv
// Signals between the PLL reset sequencer, the PLL and downstream logic.
// lock_loss_cnt is present only when PLL_RESET_SEQUENCER_LOSS_CNT_EN is defined.
interface pll_reset_sequencer_if #(
    parameter int unsigned RETRY_W = 4
);
    logic               pll_locked;
    logic               pll_rst;
    logic               sys_rst;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_count;
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    logic [7:0]         lock_loss_cnt;

    modport master (
        input  pll_locked,
        output pll_rst, sys_rst, ready, fault, retry_count, lock_loss_cnt
    );
    modport slave (
        output pll_locked,
        input  pll_rst, sys_rst, ready, fault, retry_count, lock_loss_cnt
    );
`else
    modport master (
        input  pll_locked,
        output pll_rst, sys_rst, ready, fault, retry_count
    );
    modport slave (
        output pll_locked,
        input  pll_rst, sys_rst, ready, fault, retry_count
    );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, qualifies lock over a stability window, then releases sys_rst.
// Optional lock-loss counter enabled by PLL_RESET_SEQUENCER_LOSS_CNT_EN.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 125000,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 20,
    parameter int unsigned RETRY_W        = 4
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_reset_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_SAT   = {RETRY_W{1'b1}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] r_retries;
    logic [RETRY_W-1:0] w_retries_nxt;
    logic [1:0]         r_sync;
    logic               w_locked_s;

    logic               r_pll_rst;
    logic               r_sys_rst;
    logic               r_ready;
    logic               r_fault;
    logic               w_pll_rst_nxt;
    logic               w_sys_rst_nxt;
    logic               w_ready_nxt;
    logic               w_fault_nxt;

    // Only r_sync[0] ever samples the asynchronous lock indication.
    assign w_locked_s = r_sync[1];

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= S_RESET_PLL;
            r_cnt     <= '0;
            r_retries <= '0;
            r_sync    <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retries <= w_retries_nxt;
            r_sync    <= {r_sync[0], bus.pll_locked};
            r_pll_rst <= w_pll_rst_nxt;
            r_sys_rst <= w_sys_rst_nxt;
            r_ready   <= w_ready_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    // Next state; outputs are decoded from the next state so they change on the transition edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_retries_nxt = r_retries;

        case (r_state)
            S_RESET_PLL: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TO_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_retries == RETRY_MAX) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_state_nxt   = S_RESET_PLL;
                        w_retries_nxt = (r_retries == RETRY_SAT) ? r_retries
                                                                 : r_retries + RETRY_W'(1);
                    end
                end
            end
            S_STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!w_locked_s) begin
                    w_state_nxt   = S_RESET_PLL;
                    w_retries_nxt = '0;
                end
            end
            S_FAULT: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt   = S_RESET_PLL;
                w_cnt_nxt     = '0;
                w_retries_nxt = '0;
            end
        endcase

        w_pll_rst_nxt = (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
        w_sys_rst_nxt = (w_state_nxt != S_RUN);
        w_ready_nxt   = (w_state_nxt == S_RUN);
        w_fault_nxt   = (w_state_nxt == S_FAULT);
    end

    assign bus.pll_rst     = r_pll_rst;
    assign bus.sys_rst     = r_sys_rst;
    assign bus.ready       = r_ready;
    assign bus.fault       = r_fault;
    assign bus.retry_count = r_retries;

`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;
    logic       w_loss_evt;

    assign w_loss_evt = (r_state == S_RUN) && (w_state_nxt == S_RESET_PLL);

    // Saturating count of lock losses seen while running; cleared only by rst.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_loss_cnt <= '0;
        end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign bus.lock_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumer end of the PLL `rst`/`locked` interface.
- Drives the PLL reset and watches the asynchronous `locked` output.
- Qualifies lock over a stability window and only then releases a synchronous reset to downstream logic, such as the LPDDR2 controller.
- Retries failed locks up to a bounded count, then latches a fault.

Parameters:
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per reset pulse (>=1).
- LOCK_TIMEOUT, 125000: cycles to wait for synchronized lock after a pulse (1 ms at 125 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release.
- MAX_RETRIES, 3: extra reset pulses allowed after the first before fault.
- CNT_W, 20: shared counter width; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- RETRY_W, 4: width of `retry_count`.

Ports:
- refclk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- pll_locked  in  1  PLL locked indication; asynchronous to refclk.
- pll_rst  out  1  reset to the PLL, active-high.
- sys_rst  out  1  downstream reset, active-high, synchronous to refclk.
- ready  out  1  high only while in RUN.
- fault  out  1  sticky; lock could not be obtained.
- retry_count  out  RETRY_W  retries used in the current acquisition.

Behaviour:
- All outputs are registered.
- Reset (`rst`=1 at an edge):
  - state=RESET_PLL, counter=0, retries=0, sync flops=0.
  - `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `retry_count`=0.
  - `rst` overrides every state, including mid-operation; it takes effect at the next edge.
- Synchronizer: 2-flop on `pll_locked`, giving `locked_s` with 2-cycle latency. No other logic samples raw `pll_locked`.
- RESET_PLL:
  - `pll_rst`=1, `sys_rst`=1.
  - Counter runs 0..PLL_RST_CYCLES-1; at terminal count go to WAIT_LOCK with counter=0.
  - `pll_rst` is high for exactly PLL_RST_CYCLES cycles per pulse.
- WAIT_LOCK:
  - `pll_rst`=0.
  - If `locked_s`=1: go to STABLE, counter=0.
  - Else at counter=LOCK_TIMEOUT-1:
    - retries==MAX_RETRIES: go to FAULT.
    - Otherwise: retries+1, go to RESET_PLL.
- STABLE:
  - If `locked_s`=0: go to WAIT_LOCK, counter=0. Retries are unchanged and the timeout window restarts.
  - At counter=STABLE_CYCLES-1 with `locked_s`=1: go to RUN.
- RUN:
  - `sys_rst`=0, `ready`=1.
  - If `locked_s`=0: go to RESET_PLL, retries=0. `sys_rst`=1, `ready`=0 and `pll_rst`=1 all on that same edge.
- FAULT:
  - `pll_rst`=1, `sys_rst`=1, `fault`=1.
  - Exit only via `rst`.
- Release latency: `sys_rst` falls exactly 2+STABLE_CYCLES edges after the first edge sampling `pll_locked`=1 while in WAIT_LOCK.
- Loss latency: `sys_rst` rises at most 3 edges after `pll_locked` falls in RUN.
- Simultaneous events:
  - Timeout terminal count and `locked_s`=1 in the same cycle: lock wins, go to STABLE.
  - Counter terminal in STABLE and `locked_s`=0 in the same cycle: drop wins, go to WAIT_LOCK.
- `retry_count` saturates at 2^RETRY_W-1.
- Counter never wraps; every state exit clears it.

Optional Feature:
- Macro: PLL_RESET_SEQUENCER_LOSS_CNT_EN.
- Defined:
  - Adds output `lock_loss_cnt` [7:0].
  - Increments on each RUN-to-RESET_PLL transition and saturates at 255.
  - Cleared only by `rst`.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2):
- Normal lock: release `rst`; raise `pll_locked` 6 cycles later and hold -> `pll_rst` high exactly 4 cycles; `sys_rst` falls and `ready` rises exactly 10 edges after `pll_locked` is first sampled high; `fault`=0, `retry_count`=0.
- Glitch in STABLE: `pll_locked` high 5 cycles, low 1 cycle, high again -> no release at the original point; `ready` rises 10 edges after the re-rise; `retry_count`=0.
- Timeout to fault: `pll_locked` held 0 -> three 4-cycle `pll_rst` pulses separated by 20-cycle waits; `retry_count` steps 0,1,2; `fault`=1 and `pll_rst`=1 thereafter; `rst` pulse clears `fault`.
- Loss in RUN: after `ready`=1, drop `pll_locked` -> `sys_rst`=1 and `ready`=0 within 3 edges; a 4-cycle `pll_rst` pulse follows; `retry_count`=0; re-lock releases again after 10 edges.
- Reset mid-STABLE: assert `rst` for 1 cycle during STABLE -> next edge shows `pll_rst`=1, `sys_rst`=1, `ready`=0, `retry_count`=0; a full sequence restarts.
- With PLL_RESET_SEQUENCER_LOSS_CNT_EN: 300 lock-loss/re-lock cycles -> `lock_loss_cnt` reads 255 and holds; `rst` returns it to 0.
